// File: rtl/rv64_isa_pkg.sv
// rv64_isa_pkg: RV64 R-type encoding constants, issue FSM states and the legality decoder
// shared by the issue stage and its register file.
package rv64_isa_pkg;

  localparam logic [6:0] OPCODE_OP   = 7'b0110011;

  localparam logic [2:0] FUNCT3_ADD  = 3'b000;
  localparam logic [2:0] FUNCT3_SLL  = 3'b001;
  localparam logic [2:0] FUNCT3_SLT  = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU = 3'b011;
  localparam logic [2:0] FUNCT3_XOR  = 3'b100;
  localparam logic [2:0] FUNCT3_SRL  = 3'b101;
  localparam logic [2:0] FUNCT3_OR   = 3'b110;
  localparam logic [2:0] FUNCT3_AND  = 3'b111;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DEC   = 2'd1,
    ISSUE = 2'd2
  } issue_state_t;

  // The alternate funct7 is only meaningful for SUB (ADD slot) and SRA (SRL slot).
  function automatic logic rtype_legal(input logic [31:0] instr);
    logic ok;
    ok = 1'b0;
    if (instr[6:0] != OPCODE_OP) begin
      ok = 1'b0;
    end else if (instr[31:25] == FUNCT7_BASE) begin
      ok = 1'b1;
    end else if (instr[31:25] == FUNCT7_ALT) begin
      case (instr[14:12])
        FUNCT3_ADD, FUNCT3_SRL: ok = 1'b1;
        default:                ok = 1'b0;
      endcase
    end else begin
      ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/rv64_regfile.sv
// rv64_regfile: 2-read/1-write architectural register file, x0 reads zero,
// with same-cycle write-through bypass on both read ports.
module rv64_regfile
  import rv64_isa_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] mem_r [NREG];

  // Synchronous write port; x0 is never written so it stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        mem_r[i] <= '0;
      end
    end else if (we && (waddr != 5'd0)) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Asynchronous read ports with bypass of a write landing this cycle.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 == 5'd0) begin
      rdata1 = '0;
    end else if (we && (waddr == raddr1)) begin
      rdata1 = wdata;
    end else begin
      rdata1 = mem_r[raddr1];
    end
    if (raddr2 == 5'd0) begin
      rdata2 = '0;
    end else if (we && (waddr == raddr2)) begin
      rdata2 = wdata;
    end else begin
      rdata2 = mem_r[raddr2];
    end
  end

endmodule

// File: rtl/rv64_rtype_issue.sv
// rv64_rtype_issue: decode/issue stage for the RV64 R-type ALU with a pending-destination scoreboard.
// Build macro ISSUE_PERF_CNT_EN adds the perf_issued / perf_stall counters.
module rv64_rtype_issue
  import rv64_isa_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_rs1,
  output logic [XLEN-1:0] out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_illegal,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [31:0]     perf_issued,
  output logic [31:0]     perf_stall
`endif
);

  issue_state_t    state_r;
  logic [31:0]     instr_r;
  logic [NREG-1:0] pending_r;
  logic [4:0]      rs1_idx_s;
  logic [4:0]      rs2_idx_s;
  logic [4:0]      rd_idx_s;
  logic [XLEN-1:0] rs1_val_s;
  logic [XLEN-1:0] rs2_val_s;
  logic [NREG-1:0] wb_clr_s;
  logic [NREG-1:0] rd_set_s;
  logic [NREG-1:0] pend_eff_s;
  logic            legal_s;
  logic            hazard_s;
  logic            issue_go_s;

  assign rs1_idx_s = instr_r[19:15];
  assign rs2_idx_s = instr_r[24:20];
  assign rd_idx_s  = instr_r[11:7];
  assign legal_s   = rtype_legal(instr_r);

  rv64_regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddr1 (rs1_idx_s),
    .raddr2 (rs2_idx_s),
    .rdata1 (rs1_val_s),
    .rdata2 (rs2_val_s),
    .we     (wb_en),
    .waddr  (wb_addr),
    .wdata  (wb_data)
  );

  // A writeback clears its bit before the hazard test so the stalled read can issue this cycle.
  always_comb begin
    wb_clr_s = '0;
    rd_set_s = '0;
    if (wb_en && (wb_addr != 5'd0)) begin
      wb_clr_s[wb_addr] = 1'b1;
    end else begin
      wb_clr_s = '0;
    end
    pend_eff_s = pending_r & ~wb_clr_s;
    hazard_s   = ((rs1_idx_s != 5'd0) && pend_eff_s[rs1_idx_s]) ||
                 ((rs2_idx_s != 5'd0) && pend_eff_s[rs2_idx_s]);
    issue_go_s = (state_r == DEC) && legal_s && !hazard_s;
    if (issue_go_s && (rd_idx_s != 5'd0)) begin
      rd_set_s[rd_idx_s] = 1'b1;
    end else begin
      rd_set_s = '0;
    end
  end

  // Accept while idle, or in the same cycle the held operands are handed off.
  always_comb begin
    in_ready = 1'b0;
    case (state_r)
      IDLE:    in_ready = 1'b1;
      ISSUE:   in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  // Issue FSM, registered operand outputs and scoreboard (set wins over a same-cycle clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      instr_r     <= 32'd0;
      pending_r   <= '0;
      out_valid   <= 1'b0;
      out_illegal <= 1'b0;
      out_funct3  <= 3'd0;
      out_funct7  <= 7'd0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_rd      <= 5'd0;
    end else begin
      out_illegal <= 1'b0;
      pending_r   <= pend_eff_s | rd_set_s;
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            instr_r <= in_instr;
            state_r <= DEC;
          end
        end
        DEC: begin
          if (!legal_s) begin
            out_illegal <= 1'b1;
            state_r     <= IDLE;
          end else if (!hazard_s) begin
            out_valid  <= 1'b1;
            out_funct3 <= instr_r[14:12];
            out_funct7 <= instr_r[31:25];
            out_rs1    <= rs1_val_s;
            out_rs2    <= rs2_val_s;
            out_rd     <= rd_idx_s;
            state_r    <= ISSUE;
          end
        end
        ISSUE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              instr_r <= in_instr;
              state_r <= DEC;
            end else begin
              state_r <= IDLE;
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

`ifdef ISSUE_PERF_CNT_EN
  // Handoff and hazard-stall counters; both wrap at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued <= 32'd0;
      perf_stall  <= 32'd0;
    end else begin
      if (out_valid && out_ready) begin
        perf_issued <= perf_issued + 32'd1;
      end
      if ((state_r == DEC) && legal_s && hazard_s) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule
